priv_trap_ctrl: RTL and testbench

PRIV_TRAP_CTRL -- requirements
Module: priv_trap_ctrl

---
 rtl/priv_trap_ctrl.sv | 170 +++++++++++++++++
 tb/tb_priv_trap_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_trap_ctrl.sv
// Machine-mode trap controller: latches interrupt requests, arbitrates exceptions and interrupts,
// waits for the pipeline to drain, then issues the CSR-update and PC-redirect strobes.
module priv_trap_ctrl #(
  parameter int unsigned NUM_INT     = 16,
  parameter int unsigned NUM_EXC     = 16,
  parameter int unsigned XLEN        = 32,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_INT-1:0] int_src,
  input  logic [NUM_INT-1:0] int_clr,
  input  logic [NUM_INT-1:0] int_en,
  input  logic               global_ie,
  input  logic [NUM_EXC-1:0] exc_src,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [XLEN-1:0]    epc,
  input  logic               pipe_clear,
  input  logic               mret,
  input  logic [XLEN-1:0]    mtvec_base,
  input  logic               mtvec_mode,
  input  logic [XLEN-1:0]    mepc_in,
  output logic [NUM_INT-1:0] pending,
  output logic               intr,
  output logic               busy,
  output logic               inject,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic               cause_int,
  output logic [4:0]         cause_code,
  output logic [XLEN-1:0]    next_epc,
  output logic [XLEN-1:0]    next_tval
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CLEAR = 2'd1,
    INJECT     = 2'd2,
    RETURN     = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [NUM_INT-1:0] pend_q;
  logic [NUM_INT-1:0] cand;
  logic               exc_hit;
  logic               int_hit;
  logic [4:0]         exc_code;
  logic [4:0]         int_code;
  logic               capture;
  logic               cap_int;
  logic [4:0]         cap_code;
  logic [XLEN-1:0]    vec_base;
  logic [XLEN-1:0]    trap_pc;
  logic               unused_ok;

  // Clear wins over a same-cycle set; keeps running regardless of FSM state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q | int_src) & ~int_clr;
    end
  end

  assign pending = pend_q;
  assign cand    = pend_q & int_en & {NUM_INT{global_ie}};
  assign exc_hit = |exc_src;
  assign int_hit = |cand;

  // Lowest exception index: scan downward so the last hit written is the lowest.
  always_comb begin
    exc_code = '0;
    for (int unsigned i = NUM_EXC; i > 0; i--) begin
      if (exc_src[i-1]) exc_code = 5'(i - 1);
    end
  end

  // Highest interrupt index: scan upward so the last hit written is the highest.
  always_comb begin
    int_code = '0;
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      if (cand[i]) int_code = 5'(i);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    cap_int  = 1'b0;
    cap_code = '0;
    unique case (state_q)
      IDLE: begin
        if (exc_hit) begin
          capture  = 1'b1;
          cap_code = exc_code;
          state_d  = WAIT_CLEAR;
        end else if (int_hit) begin
          capture  = 1'b1;
          cap_int  = 1'b1;
          cap_code = int_code;
          state_d  = WAIT_CLEAR;
        end else if (mret) begin
          state_d = RETURN;
        end
      end
      WAIT_CLEAR: if (pipe_clear) state_d = INJECT;
      INJECT:     state_d = IDLE;
      RETURN:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cause_int  <= 1'b0;
      cause_code <= '0;
      next_epc   <= '0;
      next_tval  <= '0;
    end else if (capture) begin
      cause_int  <= cap_int;
      cause_code <= cap_code;
      next_epc   <= epc;
      next_tval  <= cap_int ? '0 : exc_tval;
    end
  end

  assign vec_base  = {mtvec_base[XLEN-1:2], 2'b00};
  assign trap_pc   = (VECTORED_EN && mtvec_mode && cause_int)
                   ? vec_base + XLEN'({cause_code, 2'b00})
                   : vec_base;
  assign unused_ok = &{1'b0, mtvec_base[1:0]};

  always_comb begin
    intr      = 1'b0;
    busy      = 1'b0;
    inject    = 1'b0;
    insert_pc = 1'b0;
    priv_pc   = '0;
    unique case (state_q)
      IDLE: ;
      WAIT_CLEAR: begin
        intr = 1'b1;
        busy = 1'b1;
      end
      INJECT: begin
        intr      = 1'b1;
        busy      = 1'b1;
        inject    = 1'b1;
        insert_pc = 1'b1;
        priv_pc   = trap_pc;
      end
      RETURN: begin
        busy      = 1'b1;
        insert_pc = 1'b1;
        priv_pc   = mepc_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Bench for priv_trap_ctrl: directed trap scenarios followed by randomized traffic,
// compared every cycle against a behavioural model of pending/trap/return behaviour.
module tb_priv_trap_ctrl;

  localparam int unsigned NI = 16;
  localparam int unsigned NE = 16;
  localparam int unsigned XL = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NI-1:0] int_src = '0, int_clr = '0, int_en = '0;
  logic          global_ie = 1'b0;
  logic [NE-1:0] exc_src = '0;
  logic [XL-1:0] exc_tval = '0, epc = '0, mtvec_base = '0, mepc_in = '0;
  logic          pipe_clear = 1'b1, mret = 1'b0, mtvec_mode = 1'b0;
  logic [NI-1:0] pending;
  logic          intr, busy, inject, insert_pc, cause_int;
  logic [XL-1:0] priv_pc, next_epc, next_tval;
  logic [4:0]    cause_code;

  priv_trap_ctrl #(
    .NUM_INT    (NI),
    .NUM_EXC    (NE),
    .XLEN       (XL),
    .VECTORED_EN(1'b1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .int_src   (int_src),
    .int_clr   (int_clr),
    .int_en    (int_en),
    .global_ie (global_ie),
    .exc_src   (exc_src),
    .exc_tval  (exc_tval),
    .epc       (epc),
    .pipe_clear(pipe_clear),
    .mret      (mret),
    .mtvec_base(mtvec_base),
    .mtvec_mode(mtvec_mode),
    .mepc_in   (mepc_in),
    .pending   (pending),
    .intr      (intr),
    .busy      (busy),
    .inject    (inject),
    .insert_pc (insert_pc),
    .priv_pc   (priv_pc),
    .cause_int (cause_int),
    .cause_code(cause_code),
    .next_epc  (next_epc),
    .next_tval (next_tval)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: trap in flight (waiting / firing), return in flight, captured cause record.
  logic [NI-1:0] m_pend;
  bit            m_wait, m_fire, m_ret, m_ci;
  logic [4:0]    m_cc;
  logic [XL-1:0] m_epc, m_tval;

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int highest(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [XL-1:0] exp_pc();
    logic [XL-1:0] b;
    b = mtvec_base & ~32'h3;
    if (m_fire) return (mtvec_mode && m_ci) ? b + 32'(m_cc) * 32'd4 : b;
    if (m_ret) return mepc_in;
    return '0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_wait = 0; m_fire = 0; m_ret = 0;
    m_ci = 0; m_cc = '0; m_epc = '0; m_tval = '0;
  endtask

  task automatic model_step();
    logic [NI-1:0] c;
    if (RST) begin
      model_reset();
      return;
    end
    c = m_pend & int_en & {NI{global_ie}};
    if (m_fire) m_fire = 0;
    else if (m_ret) m_ret = 0;
    else if (m_wait) begin
      if (pipe_clear) begin m_wait = 0; m_fire = 1; end
    end else if (exc_src != 0) begin
      m_ci = 0; m_cc = 5'(lowest(32'(exc_src))); m_tval = exc_tval; m_epc = epc; m_wait = 1;
    end else if (c != 0) begin
      m_ci = 1; m_cc = 5'(highest(32'(c))); m_tval = '0; m_epc = epc; m_wait = 1;
    end else if (mret) m_ret = 1;
    m_pend = (m_pend | int_src) & ~int_clr;
  endtask

  task automatic compare_all();
    check_val("pending",    pending,    m_pend);
    check_val("intr",       intr,       m_wait | m_fire);
    check_val("busy",       busy,       m_wait | m_fire | m_ret);
    check_val("inject",     inject,     m_fire);
    check_val("insert_pc",  insert_pc,  m_fire | m_ret);
    check_val("priv_pc",    priv_pc,    exp_pc());
    check_val("cause_int",  cause_int,  m_ci);
    check_val("cause_code", cause_code, m_cc);
    check_val("next_epc",   next_epc,   m_epc);
    check_val("next_tval",  next_tval,  m_tval);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step_cycle();
    #1 compare_all();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic flush();
    int_src = '0; int_clr = '1; global_ie = 0; exc_src = '0; mret = 0; pipe_clear = 1;
    repeat (4) step_cycle();
    int_clr = '0;
  endtask

  task automatic run_to_inject(output logic [XL-1:0] pc_seen, output bit cint_seen);
    bit seen;
    seen = 0;
    pc_seen = '0;
    cint_seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k > 0) begin exc_src = '0; mret = 0; end
      if (busy) begin int_src = '0; int_clr = '1; end
      else int_clr = '0;
      #1;
      if (inject) begin seen = 1; pc_seen = priv_pc; cint_seen = cause_int; end
      step_cycle();
    end
    int_clr = '0;
    check_val("inject_seen", seen, 1);
  endtask

  logic [XL-1:0] pc_seen;
  bit            ci_seen;
  int unsigned   intr_cnt, inj_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 compare_all();
    @(negedge CLK);
    RST = 0;

    // Interrupt 7 with a slow pipeline drain.
    flush();
    int_en = 16'h0080; global_ie = 1; epc = 32'h100;
    int_src = 16'h0080; pipe_clear = 0;
    step_cycle();
    intr_cnt = 0; inj_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      pipe_clear = (k >= 3);
      int_src = (k < 4) ? 16'h0080 : 16'h0000;
      int_clr = (k == 4) ? 16'h0080 : 16'h0000;
      #1;
      if (intr) intr_cnt++;
      if (inject) inj_cnt++;
      step_cycle();
    end
    int_clr = '0;
    check_val("i7_intr_cycles", intr_cnt, 4);
    check_val("i7_inject_cycles", inj_cnt, 1);
    check_val("i7_cause_int", cause_int, 1);
    check_val("i7_cause_code", cause_code, 7);
    check_val("i7_next_epc", next_epc, 32'h100);

    // Vectored interrupt 11 and direct-target exception 2.
    flush();
    int_en = '1; global_ie = 1; mtvec_base = 32'h8000_0001; mtvec_mode = 1;
    int_src = 16'h0800;
    run_to_inject(pc_seen, ci_seen);
    check_val("vec_int11_pc", pc_seen, 32'h8000_002C);
    flush();
    global_ie = 1; exc_src = 16'h0004; exc_tval = 32'h55;
    run_to_inject(pc_seen, ci_seen);
    check_val("exc2_pc", pc_seen, 32'h8000_0000);
    check_val("exc2_cause_int", ci_seen, 0);

    // Exception beats a same-cycle enabled interrupt; lowest exception index wins.
    flush();
    global_ie = 1; int_en = '1; int_src = 16'h0008;
    step_cycle();
    int_src = '0; exc_src = 16'h0024; exc_tval = 32'hDEAD;
    step_cycle();
    exc_src = '0;
    #1;
    check_val("prio_cause_code", cause_code, 2);
    check_val("prio_cause_int", cause_int, 0);
    check_val("prio_tval", next_tval, 32'hDEAD);
    run_to_inject(pc_seen, ci_seen);

    // Clear beats set; global disable blocks the trap.
    flush();
    global_ie = 1; int_en = '1; int_src = 16'h0020; int_clr = 16'h0020;
    step_cycle();
    #1 check_val("clr_wins_p5", pending[5], 0);
    int_clr = '0; global_ie = 0; int_src = 16'h0020;
    step_cycle();
    int_src = '0;
    for (int k = 0; k < 4; k++) begin
      #1 check_val("gie_off_busy", busy, 0);
      step_cycle();
    end
    #1 check_val("gie_off_pend5", pending[5], 1);

    // mret alone, then mret losing to an exception.
    flush();
    mret = 1; mepc_in = 32'h2000;
    step_cycle();
    mret = 0;
    #1;
    check_val("mret_insert_pc", insert_pc, 1);
    check_val("mret_priv_pc", priv_pc, 32'h2000);
    check_val("mret_inject", inject, 0);
    step_cycle();
    #1 check_val("mret_one_cycle", insert_pc, 0);
    mret = 1; exc_src = 16'h0001; pipe_clear = 0;
    step_cycle();
    mret = 0; exc_src = '0;
    #1;
    check_val("mret_exc_intr", intr, 1);
    check_val("mret_exc_insert", insert_pc, 0);
    pipe_clear = 1;
    run_to_inject(pc_seen, ci_seen);
    check_val("mret_exc_cause_int", ci_seen, 0);

    // Reset asserted while waiting for the pipeline.
    flush();
    exc_src = 16'h0002; exc_tval = 32'h77; epc = 32'h44; pipe_clear = 0;
    step_cycle();
    exc_src = '0;
    #1 check_val("rst_pre_intr", intr, 1);
    #2 RST = 1;
    #1;
    check_val("rst_intr", intr, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_inject", inject, 0);
    check_val("rst_insert_pc", insert_pc, 0);
    check_val("rst_priv_pc", priv_pc, 0);
    check_val("rst_pending", pending, 0);
    check_val("rst_cause_code", cause_code, 0);
    check_val("rst_next_epc", next_epc, 0);
    check_val("rst_next_tval", next_tval, 0);
    model_reset();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    RST = 0; pipe_clear = 1;
    inj_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1 if (inject) inj_cnt++;
      step_cycle();
    end
    check_val("rst_no_inject", inj_cnt, 0);

    // Randomized traffic with occasional asynchronous reset.
    for (int n = 0; n < 1500; n++) begin
      int_src    = NI'($urandom & $urandom & $urandom);
      int_clr    = NI'($urandom & $urandom & $urandom);
      int_en     = NI'($urandom);
      global_ie  = ($urandom_range(0, 3) != 0);
      exc_src    = ($urandom_range(0, 9) == 0) ? NE'($urandom) : '0;
      exc_tval   = $urandom;
      epc        = $urandom;
      pipe_clear = $urandom_range(0, 1) == 1;
      mret       = ($urandom_range(0, 7) == 0);
      mtvec_base = $urandom;
      mtvec_mode = $urandom_range(0, 1) == 1;
      mepc_in    = $urandom;
      #1 compare_all();
      if ($urandom_range(0, 199) == 0) begin
        #1 RST = 1;
        #1 model_reset();
        compare_all();
        RST = 0;
      end
      @(posedge CLK);
      model_step();
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
